// File: rtl/quad_sum_counter_if.sv
// Job/load handshake and result bus for quad_sum_counter.
// The master side issues jobs and element beats; the slave side is the counter.
interface quad_sum_counter_if #(
  parameter int W     = 8,
  parameter int N_MAX = 16,
  parameter int CW    = 16
) ();
  localparam int LW = $clog2(N_MAX + 1);

  logic              start;
  logic [LW-1:0]     len;
  logic [W+1:0]      target;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [CW-1:0]     count;
  logic              overflow;

  modport master (
    output start, len, target, in_valid, in_data,
    input  in_ready, busy, done, count, overflow
  );

  modport slave (
    input  start, len, target, in_valid, in_data,
    output in_ready, busy, done, count, overflow
  );
endinterface

// File: rtl/quad_sum_counter.sv
// Loads up to N_MAX elements, then walks every quadruple i<j<k<l one per cycle
// and counts those whose sum equals the target, saturating at 2^CW-1.
module quad_sum_counter #(
  parameter int W     = 8,
  parameter int N_MAX = 16,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  quad_sum_counter_if.slave  bus
);
  localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int LW = $clog2(N_MAX + 1);
  localparam int SW = W + 2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [LW-1:0]   r_len;
  logic [SW-1:0]   r_target;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_i, r_j, r_k, r_l;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [W-1:0]    r_mem [N_MAX];

  logic [LW-1:0]   w_len_clamped;
  logic            w_accept;
  logic            w_last_beat;
  logic            w_last_quad;
  logic            w_match;
  logic [SW-1:0]   w_sum;
  logic [IW-1:0]   w_ni, w_nj, w_nk, w_nl;

  assign w_len_clamped = (bus.len > LW'(N_MAX)) ? LW'(N_MAX) : bus.len;
  assign w_accept      = (r_state == S_LOAD) && bus.in_valid;
  assign w_last_beat   = w_accept && (LW'(r_idx) == r_len - LW'(1));
  // i reaches len-4 only on the final quadruple (len-4, len-3, len-2, len-1)
  assign w_last_quad   = (LW'(r_i) == r_len - LW'(4));
  assign w_sum         = SW'(r_mem[r_i]) + SW'(r_mem[r_j]) + SW'(r_mem[r_k]) + SW'(r_mem[r_l]);
  assign w_match       = (w_sum == r_target);

  always_comb begin
    w_next       = r_state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (w_len_clamped == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (w_last_beat) w_next = (r_len >= LW'(4)) ? S_COMPUTE : S_DONE;
      end
      S_COMPUTE: begin
        bus.busy = 1'b1;
        if (w_last_quad) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lexicographic advance: the lowest index that can still move increments,
  // and every index below it restarts just above its upper neighbour.
  always_comb begin
    w_ni = r_i;
    w_nj = r_j;
    w_nk = r_k;
    w_nl = r_l;
    if (LW'(r_l) != r_len - LW'(1)) begin
      w_nl = r_l + IW'(1);
    end else if (LW'(r_k) != r_len - LW'(2)) begin
      w_nk = r_k + IW'(1);
      w_nl = r_k + IW'(2);
    end else if (LW'(r_j) != r_len - LW'(3)) begin
      w_nj = r_j + IW'(1);
      w_nk = r_j + IW'(2);
      w_nl = r_j + IW'(3);
    end else begin
      w_ni = r_i + IW'(1);
      w_nj = r_i + IW'(2);
      w_nk = r_i + IW'(3);
      w_nl = r_i + IW'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_target   <= '0;
      r_idx      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_l        <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len      <= w_len_clamped;
            r_target   <= bus.target;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
            r_i        <= IW'(0);
            r_j        <= IW'(1);
            r_k        <= IW'(2);
            r_l        <= IW'(3);
          end
        end
        S_LOAD: begin
          if (w_accept) r_idx <= r_idx + IW'(1);
        end
        S_COMPUTE: begin
          if (w_match) begin
            if (r_count == '1) r_overflow <= 1'b1;
            else               r_count    <= r_count + CW'(1);
          end
          r_i <= w_ni;
          r_j <= w_nj;
          r_k <= w_nk;
          r_l <= w_nl;
        end
        default: ;
      endcase
    end
  end

  // Element storage is plain data: never reset, only indices below len are read.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_idx] <= bus.in_data;
  end

  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_quad_sum_counter.sv
// Randomized and directed jobs for quad_sum_counter with a queue-based scoreboard;
// expected counts come from a brute-force quadruple enumeration.
module tb_quad_sum_counter;
  localparam int W     = 8;
  localparam int N_MAX = 16;
  localparam int CW    = 8;
  localparam int LW    = $clog2(N_MAX + 1);
  localparam int SW    = W + 2;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    int cnt;
    int ovf;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   last_count;
  int   elems [N_MAX];
  exp_t expq [$];

  quad_sum_counter_if #(.W(W), .N_MAX(N_MAX), .CW(CW)) bus ();

  quad_sum_counter #(.W(W), .N_MAX(N_MAX), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  function automatic int choose4(input int n);
    return (n < 4) ? 0 : n * (n - 1) * (n - 2) * (n - 3) / 24;
  endfunction

  function automatic exp_t model(input int n, input int tgt);
    exp_t e;
    int   c;
    c = 0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        for (int d = b + 1; d < n; d++)
          for (int f = d + 1; f < n; f++)
            if (elems[a] + elems[b] + elems[d] + elems[f] == tgt) c++;
    e.cnt = (c > CMAX) ? CMAX : c;
    e.ovf = (c > CMAX) ? 1 : 0;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      chk("done_expected", expq.size(), 1);
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("count", bus.count, e.cnt);
        chk("overflow", bus.overflow, e.ovf);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", bus.busy, 0);
        last_count = int'(bus.count);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N_MAX; i++) elems[i] = v;
  endtask

  task automatic set_rand(input int maxv);
    for (int i = 0; i < N_MAX; i++) elems[i] = int'($urandom_range(maxv));
  endtask

  task automatic run_job(input int n, input int tgt, input int gap_pct,
                         input bit pulses, input bit wait_done);
    exp_t e;
    int   t, u, k, eff, guard;
    bit   stalled;
    eff = (n > N_MAX) ? N_MAX : n;
    e   = model(eff, tgt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.len    = LW'(n);
    bus.target = SW'(tgt);
    t = cyc;
    if (eff == 0) begin
      e.cyc = t + 1;
      expq.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; guard = 0; stalled = 1'b0; u = t;
    while (k < eff && guard < 400) begin
      guard++;
      bus.start  = pulses && ($urandom_range(2) == 0);
      bus.len    = LW'($urandom_range(N_MAX));
      bus.target = SW'($urandom_range(20));
      if (gap_pct != 0 && int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'(elems[k]);
        if (bus.in_ready) begin
          u = cyc;
          k++;
          if (k == eff) begin
            e.cyc = u + choose4(eff) + 1;
            expq.push_back(e);
          end
        end else begin
          stalled = 1'b1;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (eff > 0 && gap_pct == 0) chk("load_no_stall", stalled, 0);
    if (k < eff) chk("load_beats", k, eff);
    if (wait_done) begin
      guard = 0;
      while (expq.size() != 0 && guard < 4000) begin
        bus.start = pulses && ($urandom_range(3) == 0);
        @(negedge clk);
        guard++;
      end
      bus.start = 1'b0;
      if (expq.size() != 0) begin
        chk("done_timeout", expq.size(), 0);
        expq.delete();
        do_reset();
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    n_checks     = 0;
    n_pass       = 0;
    last_count   = -1;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.target   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) elems[i] = i + 1;
    run_job(4, 10, 0, 0, 1);
    for (int i = 0; i < 6; i++) elems[i] = i;
    run_job(6, 10, 0, 0, 1);
    set_all(1);
    run_job(8, 4, 0, 0, 1);
    run_job(8, 5, 0, 0, 1);
    set_all(255);
    run_job(4, 1020, 0, 0, 1);
    run_job(3, 765, 0, 0, 1);
    run_job(0, 0, 0, 0, 1);
    set_all(2);
    run_job(16, 8, 0, 1, 1);
    run_job(25, 8, 0, 0, 1);

    set_rand(3);
    run_job(12, 6, 0, 0, 1);
    c1 = last_count;
    run_job(12, 6, 50, 0, 1);
    chk("gap_vs_nogap", last_count, c1);

    for (int r = 0; r < 12; r++) begin
      set_rand((r % 3 == 0) ? 255 : 3);
      run_job(int'($urandom_range(N_MAX)),
              (r % 3 == 0) ? int'($urandom_range(1020)) : int'($urandom_range(12)),
              30, 1, 1);
    end

    set_all(2);
    run_job(16, 8, 0, 0, 0);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_count", bus.count, 0);
    chk("abort_overflow", bus.overflow, 0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) elems[i] = i + 1;
    run_job(4, 10, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
